// File: rtl/gb_host_arbiter.sv
// Two-requester ghostbus host port arbiter: one transaction at a time, write strobe and read-latency wait.
// Define GB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module gb_host_arbiter #(
  parameter int unsigned AW     = 24,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic [DW-1:0] req1_rdata,
  output logic [1:0]    gnt,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  input  logic [DW-1:0] gb_din
);

  if (RD_LAT == 0 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("gb_host_arbiter: RD_LAT must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          winner;

`ifdef GB_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~req0_valid;
  end
`else
  logic last_q, last_d;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    winner = ~req0_valid;
    if (req0_valid && req1_valid) begin
      winner = ~last_q;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifndef GB_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d = winner;
          we_d    = winner ? req1_we    : req0_we;
          addr_d  = winner ? req1_addr  : req0_addr;
          dout_d  = winner ? req1_wdata : req0_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) rdata1_d = gb_din;
          else         rdata0_d = gb_din;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
`ifndef GB_ARB_FIXED_PRIO_EN
        last_d  = owner_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gb_clk) begin
    if (gb_rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef GB_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef GB_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  // Strobe, grant and ack are gated by reset so an abort takes effect in the reset cycle itself.
  always_comb begin
    gb_we    = (state_q == S_ISSUE) && we_q && !gb_rst;
    gnt      = '0;
    if ((state_q != S_IDLE) && !gb_rst) begin
      gnt = owner_q ? 2'b10 : 2'b01;
    end
    req0_ack = (state_q == S_ACK) && !owner_q && !gb_rst;
    req1_ack = (state_q == S_ACK) && owner_q && !gb_rst;
  end

  assign gb_addr    = addr_q;
  assign gb_dout    = dout_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_gb_host_arbiter.sv
// Directed bench for gb_host_arbiter: main instance at RD_LAT=2, a second at RD_LAT=1 for write spacing.
module tb_gb_host_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata, gb_din;

  logic          req0_ack, req1_ack, gb_we;
  logic [DW-1:0] req0_rdata, req1_rdata, gb_dout;
  logic [1:0]    gnt;
  logic [AW-1:0] gb_addr;

  logic          l1_ack0, l1_ack1, l1_we;
  logic [DW-1:0] l1_rdata0, l1_rdata1, l1_dout;
  logic [1:0]    l1_gnt;
  logic [AW-1:0] l1_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gb_host_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
    .gb_clk(clk), .gb_rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .gnt(gnt), .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_din(gb_din)
  );

  gb_host_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
    .gb_clk(clk), .gb_rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ack(l1_ack0), .req0_rdata(l1_rdata0),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ack(l1_ack1), .req1_rdata(l1_rdata1),
    .gnt(l1_gnt), .gb_addr(l1_addr), .gb_dout(l1_dout), .gb_we(l1_we), .gb_din(gb_din)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 20);
    check({tag, "_issued"}, 64'(gnt != 2'b00), 64'd1);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_owner;
    logic last_m;
    int   n0, n1, extra, np, npm;
    int   p[4];

    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    gb_din = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_we", gb_we, 1'b0);
    check("rst_addr", gb_addr, 0);
    check("rst_dout", gb_dout, 0);
    check("rst_ack0", req0_ack, 1'b0);
    check("rst_ack1", req1_ack, 1'b0);
    check("rst_rdata0", req0_rdata, 0);
    check("rst_rdata1", req1_rdata, 0);
    rst = 1'b0;

    // Single write
    req0_we = 1'b1; req0_addr = 24'h000204; req0_wdata = 32'hDEADBEEF; req0_valid = 1'b1;
    @(negedge clk);
    check("wr_we", gb_we, 1'b1);
    check("wr_addr", gb_addr, 24'h000204);
    check("wr_dout", gb_dout, 32'hDEADBEEF);
    check("wr_gnt", gnt, 2'b01);
    check("wr_ack_early", req0_ack, 1'b0);
    req0_addr = 24'h0FFFFF; req0_wdata = 32'h0;
    @(negedge clk);
    check("wr_ack", req0_ack, 1'b1);
    check("wr_ack1", req1_ack, 1'b0);
    check("wr_we_low", gb_we, 1'b0);
    check("wr_addr_hold", gb_addr, 24'h000204);
    req0_valid = 1'b0;
    @(negedge clk);
    check("wr_ack_done", req0_ack, 1'b0);
    check("wr_gnt_idle", gnt, 2'b00);
    check("wr_addr_after", gb_addr, 24'h000204);
    check("wr_dout_after", gb_dout, 32'hDEADBEEF);
    check("wr_rdata", req0_rdata, 0);

    // Single read, RD_LAT=2; gb_din carries the good value only in cycle ISSUE+2
    gb_din = 32'hBAD0BAD0;
    req0_we = 1'b0; req0_addr = 24'h000010; req0_valid = 1'b1;
    wait_issue("rd");
    check("rd_we", gb_we, 1'b0);
    check("rd_addr", gb_addr, 24'h000010);
    check("rd_gnt", gnt, 2'b01);
    @(negedge clk);
    check("rd_ack_t1", req0_ack, 1'b0);
    @(negedge clk);
    check("rd_ack_t2", req0_ack, 1'b0);
    gb_din = 32'h12345678;
    @(negedge clk);
    check("rd_ack", req0_ack, 1'b1);
    check("rd_data", req0_rdata, 32'h12345678);
    check("rd_we_low", gb_we, 1'b0);
    gb_din = 32'hBAD0BAD0;
    req0_valid = 1'b0;
    @(negedge clk);
    check("rd_ack_done", req0_ack, 1'b0);
    check("rd_data_hold", req0_rdata, 32'h12345678);

    // Both requesters continuously valid, four writes each
    do_reset();
    req0_we = 1'b1; req0_addr = 24'h0000A0; req0_wdata = 32'hA0A0A0A0;
    req1_we = 1'b1; req1_addr = 24'h0000B0; req1_wdata = 32'hB0B0B0B0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    last_m = 1'b1; n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (req0_valid && req1_valid) begin
`ifdef GB_ARB_FIXED_PRIO_EN
        exp_owner = 1'b0;
`else
        exp_owner = ~last_m;
`endif
      end else begin
        exp_owner = req1_valid;
      end
      wait_issue($sformatf("rr%0d", k));
      check($sformatf("rr%0d_gnt", k), gnt, exp_owner ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_addr", k), gb_addr, exp_owner ? 24'h0000B0 : 24'h0000A0);
      @(negedge clk);
      check($sformatf("rr%0d_ack", k), {req1_ack, req0_ack}, exp_owner ? 2'b10 : 2'b01);
      last_m = exp_owner;
      if (exp_owner) n1++; else n0++;
      if (n0 == 4) req0_valid = 1'b0;
      if (n1 == 4) req1_valid = 1'b0;
    end

    // req1 read whose valid drops during WAIT
    gb_din = 32'h0000CAFE;
    req1_we = 1'b0; req1_addr = 24'h000030; req1_valid = 1'b1;
    wait_issue("drop");
    check("drop_gnt", gnt, 2'b10);
    @(negedge clk);
    req1_valid = 1'b0;
    check("drop_ack_t1", req1_ack, 1'b0);
    @(negedge clk);
    check("drop_ack_t2", req1_ack, 1'b0);
    @(negedge clk);
    check("drop_ack", req1_ack, 1'b1);
    check("drop_rdata", req1_rdata, 32'h0000CAFE);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt != 2'b00 || req0_ack || req1_ack) extra++;
    end
    check("drop_no_retry", extra, 0);

    // Reset asserted during WAIT, then a fresh read
    gb_din = 32'h000055AA;
    req0_we = 1'b0; req0_addr = 24'h000040; req0_valid = 1'b1;
    wait_issue("rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_gnt", gnt, 2'b00);
    check("rst_wait_we", gb_we, 1'b0);
    check("rst_wait_ack", req0_ack, 1'b0);
    check("rst_wait_rdata1", req1_rdata, 0);
    rst = 1'b0;
    wait_issue("rst_retry");
    check("rst_retry_gnt", gnt, 2'b01);
    repeat (2) @(negedge clk);
    check("rst_retry_early", req0_ack, 1'b0);
    @(negedge clk);
    check("rst_retry_ack", req0_ack, 1'b1);
    check("rst_retry_data", req0_rdata, 32'h000055AA);
    req0_valid = 1'b0;

    // Back-to-back writes: gb_we pulses exactly 3 cycles apart
    do_reset();
    req0_we = 1'b1; req0_addr = 24'h000050; req0_wdata = 32'h1; req0_valid = 1'b1;
    np = 0; npm = 0;
    repeat (12) begin
      @(negedge clk);
      if (l1_we) begin
        if (np < 4) p[np] = cyc;
        np++;
      end
      if (gb_we) npm++;
    end
    req0_valid = 1'b0;
    check("b2b_pulses", np, 4);
    check("b2b_pulses_main", npm, 4);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b_gap%0d", k), p[k+1] - p[k], 3);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
